// File: rtl/recursive_eval_pkg.sv
// Shared types for the recursive evaluation core: controller states, mode
// encodings and the stack frame layout {n, phase, partial}.
package recursive_eval_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALL = 2'd1,
    RET  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic MODE_FIB  = 1'b0;
  localparam logic MODE_FACT = 1'b1;

  // Reference frame at the default 8-bit width; modules built at other
  // widths declare the same layout locally from their own DATA_W.
  localparam int FRAME_DATA_W = 8;

  typedef struct packed {
    logic [FRAME_DATA_W-1:0] n;
    logic                    phase;
    logic [FRAME_DATA_W-1:0] partial;
  } frame_t;

  // Packed width of one frame for a given data width.
  function automatic int frame_width(input int data_w);
    return 2 * data_w + 1;
  endfunction

endpackage

// File: rtl/recursive_eval_core_stack.sv
// Register-array frame stack with single-cycle push/pop. A simultaneous
// push and pop overwrites the top frame and leaves sp unchanged.
module frame_stack
  import recursive_eval_pkg::*;
#(
  parameter  int DATA_W  = 8,
  parameter  int DEPTH   = 16,
  localparam int PTR_W   = $clog2(DEPTH + 1),
  localparam int FRAME_W = 2 * DATA_W + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               push,
  input  logic               pop,
  input  logic [FRAME_W-1:0] din,
  output logic [FRAME_W-1:0] dout,
  output logic               full,
  output logic               empty,
  output logic [PTR_W-1:0]   sp
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [FRAME_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]   r_sp;
  logic [PTR_W-1:0]   w_sp_m1;
  logic [IDX_W-1:0]   w_top_idx;
  logic [IDX_W-1:0]   w_wr_idx;

  assign w_sp_m1   = r_sp - PTR_W'(1);
  assign w_top_idx = w_sp_m1[IDX_W-1:0];
  assign w_wr_idx  = r_sp[IDX_W-1:0];

  assign full  = (r_sp == PTR_W'(DEPTH));
  assign empty = (r_sp == '0);
  assign sp    = r_sp;
  assign dout  = r_mem[w_top_idx];

  // Frame storage: replace top on push+pop, append on push when not full.
  always_ff @(posedge clk) begin
    if (push && pop && !empty) begin
      r_mem[w_top_idx] <= din;
    end else if (push && !pop && !full) begin
      r_mem[w_wr_idx] <= din;
    end
  end

  // Stack pointer: cleared by reset or clr, otherwise tracks push/pop.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_sp <= '0;
    end else if (push && pop) begin
      r_sp <= r_sp;
    end else if (push && !full) begin
      r_sp <= r_sp + PTR_W'(1);
    end else if (pop && !empty) begin
      r_sp <= w_sp_m1;
    end
  end

endmodule

// File: rtl/recursive_eval_core.sv
// Recursive function evaluator (fib(n) or n!) driven by a CALL/RET
// controller over a hardware frame stack. Optional run statistics
// (cycles, max_depth) are enabled with the RECURSIVE_EVAL_STATS_EN macro.
module recursive_eval_core
  import recursive_eval_pkg::*;
#(
  parameter  int DATA_W      = 8,
  parameter  int STACK_DEPTH = 16,
  localparam int PTR_W       = $clog2(STACK_DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              mode,
  input  logic [DATA_W-1:0] n_in,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] result,
  output logic              err_stack,
  output logic              err_ovf
`ifdef RECURSIVE_EVAL_STATS_EN
  ,
  output logic [15:0]       cycles,
  output logic [PTR_W-1:0]  max_depth
`endif
);

  localparam int FRAME_W = 2 * DATA_W + 1;

  typedef struct packed {
    logic [DATA_W-1:0] n;
    logic              phase;
    logic [DATA_W-1:0] partial;
  } frame_w_t;

  // Sum with carry-out in the top bit.
  function automatic logic [DATA_W:0] add_wide(input logic [DATA_W-1:0] a,
                                                input logic [DATA_W-1:0] b);
    return {1'b0, a} + {1'b0, b};
  endfunction

  // Full-width product; anything above DATA_W is overflow.
  function automatic logic [2*DATA_W-1:0] mul_wide(input logic [DATA_W-1:0] a,
                                                    input logic [DATA_W-1:0] b);
    return {{DATA_W{1'b0}}, a} * {{DATA_W{1'b0}}, b};
  endfunction

  state_t              r_state;
  logic                r_mode;
  logic [DATA_W-1:0]   r_n;
  logic [DATA_W-1:0]   r_ret;
  logic [DATA_W-1:0]   r_result;
  logic                r_err_stack;
  logic                r_err_ovf;

  logic                w_push;
  logic                w_pop;
  logic                w_clr;
  logic                w_full;
  logic                w_empty;
  logic [PTR_W-1:0]    w_sp;
  logic [FRAME_W-1:0]  w_dout;
  frame_w_t            w_top;
  frame_w_t            w_new;
  logic                w_base;
  logic [DATA_W-1:0]   w_base_val;
  logic [DATA_W:0]     w_sum;
  logic [2*DATA_W-1:0] w_prod;

  frame_stack #(
    .DATA_W (DATA_W),
    .DEPTH  (STACK_DEPTH)
  ) u_stack (
    .clk   (clk),
    .rst   (rst),
    .clr   (w_clr),
    .push  (w_push),
    .pop   (w_pop),
    .din   (w_new),
    .dout  (w_dout),
    .full  (w_full),
    .empty (w_empty),
    .sp    (w_sp)
  );

  assign w_top      = w_dout;
  assign w_base     = (r_mode == MODE_FIB) ? (r_n < DATA_W'(2)) : (r_n <= DATA_W'(1));
  assign w_base_val = (r_mode == MODE_FIB) ? r_n : DATA_W'(1);
  assign w_sum      = add_wide(w_top.partial, r_ret);
  assign w_prod     = mul_wide(w_top.n, r_ret);
  assign w_clr      = (r_state == DONE);

  // Stack requests: CALL pushes the pending n, RET pops and, for the first
  // fib return, re-pushes the frame with phase=1 holding fib(n-1).
  always_comb begin
    w_push = 1'b0;
    w_pop  = 1'b0;
    w_new  = '0;
    case (r_state)
      CALL: begin
        if (!w_base) begin
          w_push  = 1'b1;
          w_new.n = r_n;
        end
      end
      RET: begin
        if (!w_empty) begin
          w_pop = 1'b1;
          if (r_mode == MODE_FIB && !w_top.phase) begin
            w_push        = 1'b1;
            w_new.n       = w_top.n;
            w_new.phase   = 1'b1;
            w_new.partial = r_ret;
          end
        end
      end
      default: ;
    endcase
  end

  // Controller and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_result    <= '0;
      r_err_stack <= 1'b0;
      r_err_ovf   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_n         <= n_in;
            r_mode      <= mode;
            r_ret       <= '0;
            r_err_stack <= 1'b0;
            r_err_ovf   <= 1'b0;
            r_state     <= CALL;
          end
        end
        CALL: begin
          if (w_base) begin
            r_ret   <= w_base_val;
            r_state <= RET;
          end else if (w_full) begin
            r_err_stack <= 1'b1;
            r_result    <= '0;
            r_state     <= DONE;
          end else begin
            r_n <= r_n - DATA_W'(1);
          end
        end
        RET: begin
          if (w_sp == '0) begin
            r_result <= r_ret;
            r_state  <= DONE;
          end else if (r_mode == MODE_FIB) begin
            if (!w_top.phase) begin
              r_n     <= w_top.n - DATA_W'(2);
              r_state <= CALL;
            end else begin
              r_ret <= w_sum[DATA_W-1:0];
              if (w_sum[DATA_W]) r_err_ovf <= 1'b1;
            end
          end else begin
            r_ret <= w_prod[DATA_W-1:0];
            if (|w_prod[2*DATA_W-1:DATA_W]) r_err_ovf <= 1'b1;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign busy      = (r_state == CALL) || (r_state == RET);
  assign done      = (r_state == DONE);
  assign result    = r_result;
  assign err_stack = r_err_stack;
  assign err_ovf   = r_err_ovf;

`ifdef RECURSIVE_EVAL_STATS_EN
  logic [15:0]      r_cycles;
  logic [PTR_W-1:0] r_max_depth;

  // Run statistics: saturating CALL+RET cycle count and stack high-water mark.
  always_ff @(posedge clk) begin
    if (rst || (r_state == IDLE && start)) begin
      r_cycles    <= '0;
      r_max_depth <= '0;
    end else if (busy) begin
      if (r_cycles != 16'hFFFF) r_cycles <= r_cycles + 16'd1;
      if (w_sp > r_max_depth) r_max_depth <= w_sp;
    end
  end

  assign cycles    = r_cycles;
  assign max_depth = r_max_depth;
`endif

endmodule

// File: tb/tb_recursive_eval_core.sv
// Directed bench for recursive_eval_core: a default-size instance (A) and a
// 4-frame instance (B) for stack overflow cases.
module tb_recursive_eval_core;

  localparam int LIMIT = 10000;

  logic       clk = 1'b0;
  logic       rst;
  logic       a_start, a_mode, b_start, b_mode;
  logic [7:0] a_n, b_n;
  logic       a_busy, a_done, a_es, a_eo;
  logic       b_busy, b_done, b_es, b_eo;
  logic [7:0] a_result, b_result;
`ifdef RECURSIVE_EVAL_STATS_EN
  logic [15:0] a_cycles, b_cycles;
  logic [4:0]  a_maxd;
  logic [2:0]  b_maxd;
`endif

  always #5 clk = ~clk;

  recursive_eval_core #(.DATA_W(8), .STACK_DEPTH(16)) u_a (
    .clk(clk), .rst(rst), .start(a_start), .mode(a_mode), .n_in(a_n),
    .busy(a_busy), .done(a_done), .result(a_result),
    .err_stack(a_es), .err_ovf(a_eo)
`ifdef RECURSIVE_EVAL_STATS_EN
    , .cycles(a_cycles), .max_depth(a_maxd)
`endif
  );

  recursive_eval_core #(.DATA_W(8), .STACK_DEPTH(4)) u_b (
    .clk(clk), .rst(rst), .start(b_start), .mode(b_mode), .n_in(b_n),
    .busy(b_busy), .done(b_done), .result(b_result),
    .err_stack(b_es), .err_ovf(b_eo)
`ifdef RECURSIVE_EVAL_STATS_EN
    , .cycles(b_cycles), .max_depth(b_maxd)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Start one run on the chosen instance and wait (bounded) for done.
  task automatic run(input int which, input logic m, input logic [7:0] n,
                     output logic [7:0] res, output logic eo, output logic es,
                     output logic bsy1, output int lat, output bit ok);
    @(negedge clk);
    if (which == 0) begin a_start = 1'b1; a_mode = m; a_n = n; end
    else            begin b_start = 1'b1; b_mode = m; b_n = n; end
    @(posedge clk);
    #1;
    a_start = 1'b0;
    b_start = 1'b0;
    lat  = 1;
    ok   = 1'b0;
    res  = '0;
    eo   = 1'b0;
    es   = 1'b0;
    bsy1 = 1'b0;
    while (lat < LIMIT) begin
      @(negedge clk);
      if (lat == 1) bsy1 = (which == 0) ? a_busy : b_busy;
      if ((which == 0) ? a_done : b_done) begin
        ok  = 1'b1;
        res = (which == 0) ? a_result : b_result;
        eo  = (which == 0) ? a_eo : b_eo;
        es  = (which == 0) ? a_es : b_es;
        break;
      end
      @(posedge clk);
      lat++;
    end
  endtask

  typedef struct {
    int         dut;
    bit         mode;
    logic [7:0] n;
    logic [7:0] res;
    bit         eo;
    bit         es;
    int         lat;
    string      name;
  } vec_t;

  vec_t vecs[13];

  initial begin
    logic [7:0] res;
    logic       eo, es, bsy1;
    int         lat;
    bit         ok;
    int         extra;

    vecs[0]  = '{0, 1'b0, 8'd0,  8'd0,   1'b0, 1'b0, 3, "fib0"};
    vecs[1]  = '{0, 1'b0, 8'd1,  8'd1,   1'b0, 1'b0, 3, "fib1"};
    vecs[2]  = '{0, 1'b0, 8'd10, 8'd55,  1'b0, 1'b0, 0, "fib10"};
    vecs[3]  = '{0, 1'b0, 8'd13, 8'd233, 1'b0, 1'b0, 0, "fib13"};
    vecs[4]  = '{0, 1'b0, 8'd14, 8'd121, 1'b1, 1'b0, 0, "fib14"};
    vecs[5]  = '{0, 1'b1, 8'd5,  8'd120, 1'b0, 1'b0, 0, "fact5"};
    vecs[6]  = '{0, 1'b1, 8'd6,  8'd208, 1'b1, 1'b0, 0, "fact6"};
    vecs[7]  = '{0, 1'b1, 8'd0,  8'd1,   1'b0, 1'b0, 3, "fact0"};
    vecs[8]  = '{0, 1'b1, 8'd1,  8'd1,   1'b0, 1'b0, 3, "fact1"};
    vecs[9]  = '{1, 1'b1, 8'd6,  8'd0,   1'b0, 1'b1, 0, "d4_fact6"};
    vecs[10] = '{1, 1'b1, 8'd4,  8'd24,  1'b0, 1'b0, 0, "d4_fact4"};
    vecs[11] = '{1, 1'b0, 8'd5,  8'd5,   1'b0, 1'b0, 0, "d4_fib5"};
    vecs[12] = '{1, 1'b0, 8'd6,  8'd0,   1'b0, 1'b1, 0, "d4_fib6"};

    rst = 1'b1;
    a_start = 1'b0; a_mode = 1'b0; a_n = '0;
    b_start = 1'b0; b_mode = 1'b0; b_n = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy",   a_busy,   0);
    check("rst_done",   a_done,   0);
    check("rst_result", a_result, 0);
    check("rst_estack", a_es,     0);
    check("rst_eovf",   a_eo,     0);
    check("rst_b_busy", b_busy,   0);
    rst = 1'b0;

    for (int i = 0; i < 13; i++) begin
      run(vecs[i].dut, vecs[i].mode, vecs[i].n, res, eo, es, bsy1, lat, ok);
      check({vecs[i].name, "_done_seen"}, ok, 1);
      check({vecs[i].name, "_result"},    res, vecs[i].res);
      check({vecs[i].name, "_err_ovf"},   eo,  vecs[i].eo);
      check({vecs[i].name, "_err_stack"}, es,  vecs[i].es);
      check({vecs[i].name, "_busy"},      bsy1, 1);
      if (vecs[i].lat != 0) check({vecs[i].name, "_latency"}, lat, vecs[i].lat);
    end

    // start held through a run, n_in changed after capture, start high in DONE
    @(negedge clk);
    a_start = 1'b1; a_mode = 1'b0; a_n = 8'd5;
    @(posedge clk);
    #1 a_n = 8'd9;
    ok = 1'b0;
    for (int c = 0; c < LIMIT; c++) begin
      @(negedge clk);
      if (a_done) begin ok = 1'b1; break; end
    end
    check("held_done_seen", ok, 1);
    check("held_result", a_result, 5);
    a_start = 1'b0;
    @(negedge clk);
    check("done_one_cycle", a_done, 0);
    extra = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (a_done || a_busy) extra++;
    end
    check("held_no_restart", extra, 0);

    // reset in the middle of a long run
    @(negedge clk);
    a_start = 1'b1; a_mode = 1'b0; a_n = 8'd10;
    @(posedge clk);
    #1 a_start = 1'b0;
    repeat (20) @(negedge clk);
    check("midrun_busy", a_busy, 1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("rst_mid_busy",   a_busy,   0);
    check("rst_mid_result", a_result, 0);
    check("rst_mid_done",   a_done,   0);
    rst = 1'b0;
    run(0, 1'b0, 8'd6, res, eo, es, bsy1, lat, ok);
    check("post_rst_done_seen", ok, 1);
    check("post_rst_fib6", res, 8);
    check("post_rst_eovf", eo, 0);

`ifdef RECURSIVE_EVAL_STATS_EN
    run(0, 1'b0, 8'd0, res, eo, es, bsy1, lat, ok);
    check("stats_fib0_cycles", a_cycles, 2);
    check("stats_fib0_depth",  a_maxd,   0);
    run(0, 1'b1, 8'd3, res, eo, es, bsy1, lat, ok);
    check("stats_fact3_result", res, 6);
    check("stats_fact3_cycles", a_cycles, 6);
    check("stats_fact3_depth",  a_maxd,   2);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/recursive_eval_core.md
Name: recursive_eval_core

Overview:
- Parametrised successor to the fixed 8-bit Fibonacci datapath: a self-contained controller and datapath that evaluates recursive functions on a hardware frame stack.
- Two modes: Fibonacci or factorial of n_in.
- Generalised in data width and stack depth; adds a start/done handshake, stack-overflow and arithmetic-overflow detection, and a busy indication.
- Sits under the top-level wrapper in place of the hand-sequenced datapath/controller pair.

Parameters:
DATA_W, 8, width of n, partial results and result
STACK_DEPTH, 16, number of frames the internal stack holds
PTR_W, $clog2(STACK_DEPTH+1), stack pointer width (derived, not overridden)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous, active-high reset
start  in  1  begin evaluation; sampled only in IDLE
mode  in  1  0 = fib(n), 1 = n!
n_in  in  DATA_W  argument, captured with start
busy  out  1  high from the cycle after start until done
done  out  1  one-cycle pulse when result is valid
result  out  DATA_W  final value; held until next start
err_stack  out  1  stack overflow; valid with done
err_ovf  out  1  arithmetic overflow (truncated result); sticky per run, valid with done

Behaviour:
- Reset: state IDLE, sp=0, busy=0, done=0, result=0, err_stack=0, err_ovf=0.
- Reset mid-run aborts the run; the stack contents are discarded.
- Frame layout: {n[DATA_W], phase[1], partial[DATA_W]}.
- The stack is a register array; push and pop are single-cycle.
- States (one cycle each): IDLE, CALL, RET, DONE.
- IDLE + start:
  - capture n=n_in and mode;
  - clear err_ovf, err_stack and ret;
  - go to CALL.
  - start is ignored in every other state.
- CALL, fib:
  - n<2: ret=n, go to RET.
  - else push {n,0,0}, n=n-1, stay in CALL.
- CALL, fact:
  - n<=1: ret=1, go to RET.
  - else push {n,0,0}, n=n-1, stay in CALL.
- RET, sp==0: result=ret, go to DONE.
- RET, fib, pop {fn,ph,p}:
  - ph=0: push {fn,1,ret}, n=fn-2, go to CALL. Pop and push happen in the same cycle, so sp is unchanged.
  - ph=1: ret=p+ret, stay in RET.
- RET, fact, pop {fn,-,-}: ret=fn*ret truncated to DATA_W, stay in RET.
- Arithmetic: carry-out of the add, or any nonzero bit above DATA_W of the 2*DATA_W product, sets err_ovf. err_ovf is sticky; the run continues with the truncated value.
- Push attempted at sp==STACK_DEPTH:
  - set err_stack;
  - result=0;
  - go straight to DONE; the remaining frames are abandoned and sp is cleared.
- DONE: done=1 for one cycle, busy=0 from the next cycle, sp=0, return to IDLE.
- busy=1 in CALL and RET; busy=0 in IDLE and DONE.
- A start asserted in the DONE cycle is ignored.
- Latency is data-dependent; fib(0) or fib(1): start in cycle t, done in cycle t+3.

Optional Feature:
- Macro: RECURSIVE_EVAL_STATS_EN.
- Defined: adds outputs cycles[15:0] and max_depth[PTR_W-1:0].
  - cycles counts CALL+RET cycles of the run, saturating at 16'hFFFF.
  - max_depth is the high-water mark of sp.
  - Both are cleared on start and reset, and hold after done.
- Undefined: these ports and their logic are absent; all other behaviour is identical.

Decomposition:
- Package recursive_eval_pkg holds:
  - state enum (IDLE, CALL, RET, DONE);
  - MODE_FIB=1'b0, MODE_FACT=1'b1;
  - frame struct typedef generated from DATA_W.
- Sub-module frame_stack (parametrised DATA width and DEPTH):
  - ports: push, pop, din, dout, full, empty, sp;
  - simultaneous push+pop replaces the top frame.

Test Plan:
- DATA_W=8: mode=0, n_in=0 -> result=0, done exactly 3 cycles after start, no errors. Repeat with n_in=1 -> result=1.
- mode=0, n_in=10 -> result=55, err_ovf=0. n_in=13 -> 233, err_ovf=0. n_in=14 -> result=121 (377 mod 256), err_ovf=1.
- mode=1: n_in=5 -> 120, err_ovf=0. n_in=6 -> 208 (720 mod 256), err_ovf=1. n_in=0 -> 1.
- STACK_DEPTH=4, mode=1, n_in=6 (needs 5 frames) -> done with err_stack=1, result=0. Following start with n_in=4 -> result=24, err_stack=0.
- start held high through a run, plus start pulse during busy -> exactly one done per accepted start; the captured n is unchanged.
- rst asserted mid-run (fib 10) -> next cycle busy=0, result=0. A new start with fib(6) -> 8.
